// File: rtl/fruit_launcher_if.sv
// Launch bus between the fruit launcher (master) and the fruit motion block (slave).
interface fruit_launcher_if;
    logic       newfruit;
    logic [9:0] launchX;
    logic [9:0] launchY;
    logic [9:0] launchVX;
    logic [9:0] launchVY;
    logic [7:0] launch_count;
    logic       fruit_active;

    modport master (
        output newfruit, launchX, launchY, launchVX, launchVY, launch_count,
        input  fruit_active
    );

    modport slave (
        input  newfruit, launchX, launchY, launchVX, launchVY, launch_count,
        output fruit_active
    );
endinterface

// File: rtl/fruit_launcher.sv
// Spawn controller: paces fruit launches with a randomized gap and supplies a
// pseudo-random start position/velocity to the fruit motion block.
module fruit_launcher #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [7:0]  GAP_MIN   = 8'd30,
    parameter logic [9:0]  X_MIN     = 10'd64,
    parameter logic [9:0]  Y_START   = 10'd479,
    parameter logic [9:0]  VY_BASE   = 10'd12
) (
    input  logic           frame_clk,
    input  logic           Reset_n,
    input  logic           enable,
    fruit_launcher_if.master bus
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GAP      = 3'd1,
        ARM      = 3'd2,
        LAUNCH   = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;
    logic [8:0]  gap_cnt;
    logic [1:0]  ack_cnt;

    logic [8:0]  gap_reload;
    logic [9:0]  arm_x;
    logic [9:0]  arm_vy;
    logic [9:0]  arm_spd;
    logic [9:0]  arm_vx;

    assign lfsr_nx    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    assign gap_reload = {1'b0, GAP_MIN} + {3'b000, lfsr[5:0]};

    // Horizontal velocity always points toward the screen centre (x = 320).
    assign arm_x   = X_MIN + {1'b0, lfsr[8:0]};
    assign arm_vy  = 10'd0 - (VY_BASE + {7'd0, lfsr[11:9]});
    assign arm_spd = 10'd1 + {8'd0, lfsr[13:12]};
    assign arm_vx  = (arm_x < 10'd320) ? arm_spd : (10'd0 - arm_spd);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: registers are always updated with non-blocking assignments.
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no latch is inferred.
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable) state_nx = GAP;
            end
            GAP: begin
                if (!enable)
                    state_nx = IDLE;
                else if (gap_cnt == 9'd0 && !bus.fruit_active)
                    state_nx = ARM;
            end
            ARM: begin
                state_nx = enable ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                state_nx = enable ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                if (!enable)
                    state_nx = IDLE;
                else if (bus.fruit_active || ack_cnt == 2'd2)
                    state_nx = GAP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr             <= SEED;
            gap_cnt          <= 9'd0;
            ack_cnt          <= 2'd0;
            bus.newfruit     <= 1'b0;
            bus.launchX      <= X_MIN;
            bus.launchY      <= Y_START;
            bus.launchVX     <= 10'd0;
            bus.launchVY     <= 10'd0;
            bus.launch_count <= 8'd0;
        end else begin
            lfsr <= lfsr_nx;

            if (state_nx == GAP && state != GAP)
                gap_cnt <= gap_reload;
            else if (state == GAP && gap_cnt != 9'd0)
                gap_cnt <= gap_cnt - 9'd1;

            // Timeout counter: WAIT_ACK lasts at most three cycles without an ack.
            ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 2'd1 : 2'd0;

            if (state == ARM && enable) begin
                bus.launchX  <= arm_x;
                bus.launchY  <= Y_START;
                bus.launchVX <= arm_vx;
                bus.launchVY <= arm_vy;
            end

            bus.newfruit <= (state_nx == LAUNCH);
            if (state_nx == LAUNCH && bus.launch_count != 8'hFF)
                bus.launch_count <= bus.launch_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fruit_launcher.sv
// Directed bench for fruit_launcher: reset state, LFSR stepping, launch timing,
// hold-off, ack timeout, disable, reset during LAUNCH and count saturation.
module tb_fruit_launcher;

    localparam int ST_IDLE     = 0;
    localparam int ST_GAP      = 1;
    localparam int ST_ARM      = 2;
    localparam int ST_WAIT_ACK = 4;

    logic frame_clk = 1'b0;
    logic rst_n;
    logic en_def, en_zero, en_main, en_sat;

    int n_tests = 0;
    int n_fail  = 0;

    fruit_launcher_if if_def ();
    fruit_launcher_if if_zero ();
    fruit_launcher_if if_main ();
    fruit_launcher_if if_sat ();

    fruit_launcher u_def (
        .frame_clk (frame_clk), .Reset_n (rst_n), .enable (en_def), .bus (if_def.master)
    );
    fruit_launcher #(.LFSR_SEED(16'h0000)) u_zero (
        .frame_clk (frame_clk), .Reset_n (rst_n), .enable (en_zero), .bus (if_zero.master)
    );
    fruit_launcher #(.GAP_MIN(8'd2)) u_main (
        .frame_clk (frame_clk), .Reset_n (rst_n), .enable (en_main), .bus (if_main.master)
    );
    fruit_launcher #(.GAP_MIN(8'd0)) u_sat (
        .frame_clk (frame_clk), .Reset_n (rst_n), .enable (en_sat), .bus (if_sat.master)
    );

    always #5 frame_clk = ~frame_clk;

    // Reference LFSR for u_main (default seed); m_prev is the previous cycle's value.
    logic [15:0] m_lfsr, m_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    logic [9:0] exp_x, exp_vx, exp_vy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_main_nf(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge frame_clk);
            if (if_main.newfruit) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    // Called in the LAUNCH cycle: the parameters came from the lfsr value during ARM.
    task automatic check_launch(input string tag, input logic [7:0] exp_cnt);
        logic [15:0] v;
        logic [9:0]  spd, vx, mag;
        v      = m_prev;
        exp_x  = 10'd64 + {1'b0, v[8:0]};
        exp_vy = 10'd0 - (10'd12 + {7'd0, v[11:9]});
        spd    = 10'd1 + {8'd0, v[13:12]};
        exp_vx = (exp_x < 10'd320) ? spd : (10'd0 - spd);
        check({tag, "_x"},     32'(if_main.launchX), 32'(exp_x));
        check({tag, "_y"},     32'(if_main.launchY), 32'd479);
        check({tag, "_vx"},    32'(if_main.launchVX), 32'(exp_vx));
        check({tag, "_vy"},    32'(if_main.launchVY), 32'(exp_vy));
        check({tag, "_count"}, 32'(if_main.launch_count), 32'(exp_cnt));
        vx  = if_main.launchVX;
        mag = vx[9] ? (10'd0 - vx) : vx;
        check({tag, "_x_range"},
              32'(if_main.launchX >= 10'd64 && if_main.launchX <= 10'd575), 32'd1);
        check({tag, "_vy_range"},
              32'(if_main.launchVY >= 10'h3ED && if_main.launchVY <= 10'h3F4), 32'd1);
        check({tag, "_vx_mag"}, 32'(mag >= 10'd1 && mag <= 10'd4), 32'd1);
        check({tag, "_vx_dir"}, 32'((if_main.launchX < 10'd320) == !vx[9]), 32'd1);
    endtask

    task automatic check_main_reset(input string tag);
        check({tag, "_nf"},    32'(if_main.newfruit), 32'd0);
        check({tag, "_x"},     32'(if_main.launchX), 32'd64);
        check({tag, "_y"},     32'(if_main.launchY), 32'd479);
        check({tag, "_vx"},    32'(if_main.launchVX), 32'd0);
        check({tag, "_vy"},    32'(if_main.launchVY), 32'd0);
        check({tag, "_count"}, 32'(if_main.launch_count), 32'd0);
    endtask

    initial begin
        bit hit;
        int pulses;

        rst_n   = 1'b0;
        en_def  = 1'b0;
        en_zero = 1'b0;
        en_main = 1'b1;
        en_sat  = 1'b0;
        if_def.fruit_active  = 1'b0;
        if_zero.fruit_active = 1'b0;
        if_main.fruit_active = 1'b0;
        if_sat.fruit_active  = 1'b0;

        repeat (2) @(negedge frame_clk);
        rst_n = 1'b1;
        check_main_reset("rst");
        check("rst_lfsr_def",  32'(u_def.lfsr), 32'h0000ACE1);
        check("rst_lfsr_zero", 32'(u_zero.lfsr), 32'h00000001);
        check("rst_gap_cnt",   32'(u_main.gap_cnt), 32'd0);

        @(negedge frame_clk);
        check("lfsr_step_def",  32'(u_def.lfsr), 32'h0000E270);
        check("lfsr_step_zero", 32'(u_zero.lfsr), 32'h0000B400);

        // Basic launch, then hold the fruit on screen indefinitely.
        wait_main_nf(68, hit);
        check("basic_seen", 32'(hit), 32'd1);
        check_launch("basic", 8'd1);
        if_main.fruit_active = 1'b1;
        @(negedge frame_clk);
        check("strobe_width", 32'(if_main.newfruit), 32'd0);

        pulses = 0;
        repeat (100) begin
            @(negedge frame_clk);
            if (if_main.newfruit) pulses++;
        end
        check("holdoff_no_nf", 32'(pulses), 32'd0);
        check("holdoff_gap0",  32'(u_main.gap_cnt), 32'd0);
        check("holdoff_state", 32'(u_main.state), ST_GAP);

        if_main.fruit_active = 1'b0;
        @(negedge frame_clk);
        check("holdoff_arm_state", 32'(u_main.state), ST_ARM);
        check("holdoff_arm_nf",    32'(if_main.newfruit), 32'd0);
        @(negedge frame_clk);
        check("holdoff_nf", 32'(if_main.newfruit), 32'd1);
        check_launch("holdoff", 8'd2);

        // Never acknowledge: WAIT_ACK times out into GAP on the 4th cycle.
        repeat (3) @(negedge frame_clk);
        check("timeout_wait", 32'(u_main.state), ST_WAIT_ACK);
        @(negedge frame_clk);
        check("timeout_gap", 32'(u_main.state), ST_GAP);
        wait_main_nf(68, hit);
        check("timeout_next_seen", 32'(hit), 32'd1);
        check_launch("timeout", 8'd3);

        // Disable while in GAP.
        repeat (4) @(negedge frame_clk);
        check("dis_pre_gap", 32'(u_main.state), ST_GAP);
        en_main = 1'b0;
        @(negedge frame_clk);
        check("dis_idle", 32'(u_main.state), ST_IDLE);
        pulses = 0;
        repeat (100) begin
            @(negedge frame_clk);
            if (if_main.newfruit) pulses++;
        end
        check("dis_no_nf",  32'(pulses), 32'd0);
        check("dis_hold_x",  32'(if_main.launchX), 32'(exp_x));
        check("dis_hold_y",  32'(if_main.launchY), 32'd479);
        check("dis_hold_vx", 32'(if_main.launchVX), 32'(exp_vx));
        check("dis_hold_vy", 32'(if_main.launchVY), 32'(exp_vy));
        check("dis_hold_count", 32'(if_main.launch_count), 32'd3);

        // Reset asserted in the middle of a LAUNCH cycle.
        en_main = 1'b1;
        wait_main_nf(80, hit);
        check("midrst_seen", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check_main_reset("midrst");
        en_main = 1'b0;
        @(negedge frame_clk);
        rst_n = 1'b1;

        // Saturation with a fast-acking motion block.
        en_sat = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            hit = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(negedge frame_clk);
                if (if_sat.newfruit) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) begin
                check("sat_launch_seen", 32'(n), 32'd0);
                break;
            end
            if (n == 100) check("sat_count_100", 32'(if_sat.launch_count), 32'd100);
            if (n == 255) check("sat_count_255", 32'(if_sat.launch_count), 32'd255);
            if (n == 300) check("sat_count_300", 32'(if_sat.launch_count), 32'd255);
            if_sat.fruit_active = 1'b1;
            @(negedge frame_clk);
            @(negedge frame_clk);
            if_sat.fruit_active = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
